// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: scan codes, frame FSM states,
// and small classification/parity helpers.
package ps2_key_decoder_pkg;

   // Glyph-select keys
   localparam logic [7:0] KEY_F      = 8'h2B;
   localparam logic [7:0] KEY_Q      = 8'h15;
   localparam logic [7:0] KEY_H      = 8'h33;
   localparam logic [7:0] KEY_X      = 8'h22;
   // Movement keys
   localparam logic [7:0] KEY_I      = 8'h43;
   localparam logic [7:0] KEY_K      = 8'h42;
   localparam logic [7:0] KEY_J      = 8'h3B;
   localparam logic [7:0] KEY_L      = 8'h4B;
   // Sequence prefixes
   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

   // Odd parity holds when data plus parity bit contain an odd number of ones.
   function automatic logic parity_odd_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   function automatic logic is_glyph(input logic [7:0] code);
      logic hit;
      case (code)
         KEY_F, KEY_Q, KEY_H, KEY_X: hit = 1'b1;
         default:                    hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic logic is_move(input logic [7:0] code);
      logic hit;
      case (code)
         KEY_I, KEY_K, KEY_J, KEY_L: hit = 1'b1;
         default:                    hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronisers, ps2_clk glitch
// filter, 11-bit frame FSM and mid-frame timeout.
module ps2_key_decoder_rx_frame
   import ps2_key_decoder_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_valid,
   output logic       o_rx_err,
   output logic       o_rx_timeout
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
   logic          r_clk_filt;
   logic [FW-1:0] r_filt_cnt;
   logic [TW-1:0] r_to_cnt;
   rx_state_t     r_state;
   rx_state_t     w_state_nxt;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_cnt;
   logic          r_par_err;
   logic [7:0]    r_byte;
   logic          r_valid, r_err, r_timeout;
   logic          w_fall, w_timeout, w_valid_nxt, w_err_nxt;

   // Bit strobe: the filter is about to accept a high-to-low transition.
   assign w_fall    = r_clk_filt && !r_clk_sync && (r_filt_cnt == FILT_LAST);
   // Timeout fires only mid-frame and never on a strobe cycle.
   assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LAST);

   // Two-flop synchronisers; idle PS/2 lines are high.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= i_ps2_clk;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= i_ps2_data;
         r_dat_sync <= r_dat_meta;
      end
   end

   // Clock filter: accept a new level after FILTER_LEN consecutive differing samples.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_clk_filt <= 1'b1;
         r_filt_cnt <= '0;
      end else if (r_clk_sync == r_clk_filt) begin
         r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
         r_clk_filt <= r_clk_sync;
         r_filt_cnt <= '0;
      end else begin
         r_filt_cnt <= r_filt_cnt + {{(FW-1){1'b0}}, 1'b1};
      end
   end

   // Timeout counter: runs mid-frame, cleared by every strobe and in IDLE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_to_cnt <= '0;
      end else if (w_fall || w_timeout || (r_state == ST_IDLE)) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + {{(TW-1){1'b0}}, 1'b1};
      end
   end

   // Frame FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame FSM next-state and completion/error decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
         w_err_nxt   = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               if (!r_dat_sync) begin
                  w_state_nxt = ST_DATA;
               end else begin
                  w_err_nxt   = 1'b1;
               end
            end
            ST_DATA: begin
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = ST_PARITY;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end
            ST_PARITY: begin
               w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (r_dat_sync && !r_par_err) begin
                  w_valid_nxt = 1'b1;
               end else begin
                  w_err_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Frame datapath: shift register, bit counter, parity check, output pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift   <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_par_err <= 1'b0;
         r_byte    <= 8'h00;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid   <= w_valid_nxt;
         r_err     <= w_err_nxt;
         r_timeout <= w_timeout;
         if (w_fall) begin
            case (r_state)
               ST_IDLE: begin
                  r_bit_cnt <= 3'd0;
                  r_par_err <= 1'b0;
               end
               ST_DATA: begin
                  r_shift   <= {r_dat_sync, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               ST_PARITY: begin
                  r_par_err <= ~parity_odd_ok(r_shift, r_dat_sync);
               end
               ST_STOP: begin
                  if (w_valid_nxt) begin
                     r_byte <= r_shift;
                  end
               end
               default: begin
                  r_bit_cnt <= 3'd0;
               end
            endcase
         end
      end
   end

   assign o_rx_byte    = r_byte;
   assign o_rx_valid   = r_valid;
   assign o_rx_err     = r_err;
   assign o_rx_timeout = r_timeout;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: strips break/extended sequences and reports
// glyph and movement make codes to the mask stage.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
)(
   input  logic       Pixelclock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] character,
   output logic       char_check,
   output logic       move_check,
   output logic       frame_error
);

   logic [7:0] w_rx_byte;
   logic       w_rx_valid, w_rx_err, w_rx_timeout;
   logic       r_brk, r_ext;

   ps2_key_decoder_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .i_clk        (Pixelclock),
      .i_reset      (reset),
      .i_ps2_clk    (ps2_clk),
      .i_ps2_data   (ps2_data),
      .o_rx_byte    (w_rx_byte),
      .o_rx_valid   (w_rx_valid),
      .o_rx_err     (w_rx_err),
      .o_rx_timeout (w_rx_timeout)
   );

   // Prefix tracking, code classification and registered outputs.
   always_ff @(posedge Pixelclock) begin
      if (reset) begin
         r_brk       <= 1'b0;
         r_ext       <= 1'b0;
         character   <= 8'h00;
         char_check  <= 1'b0;
         move_check  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         char_check  <= 1'b0;
         move_check  <= 1'b0;
         frame_error <= w_rx_err;
         if (w_rx_timeout) begin
            // A stalled frame may have been the key after a prefix; forget it.
            r_brk <= 1'b0;
            r_ext <= 1'b0;
         end else if (w_rx_valid) begin
            if (w_rx_byte == CODE_BREAK) begin
               r_brk <= 1'b1;
            end else if (w_rx_byte == CODE_EXT) begin
               r_ext <= 1'b1;
            end else if (r_brk || r_ext) begin
               // Releases and extended keys are swallowed.
               r_brk <= 1'b0;
               r_ext <= 1'b0;
            end else if (is_glyph(w_rx_byte)) begin
               character  <= w_rx_byte;
               char_check <= 1'b1;
            end else if (is_move(w_rx_byte)) begin
               character  <= w_rx_byte;
               move_check <= 1'b1;
            end else begin
               character  <= character;
            end
         end else begin
            r_brk <= r_brk;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a PS/2 device model drives frames and
// pulse counters observe the outputs on the falling clock edge.
module tb_ps2_key_decoder;

   localparam int FLEN = 8;
   localparam int TOUT = 600;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic [7:0] character;
   logic       char_check, move_check, frame_error;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_char = 0, n_move = 0, n_err = 0, n_both = 0, n_wide = 0;
   int last_pulse_cyc = 0;
   int fall_cyc = 0;
   logic prev_c = 1'b0, prev_m = 1'b0, prev_e = 1'b0;
   int c0, m0, e0;

   ps2_key_decoder #(
      .FILTER_LEN     (FLEN),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .Pixelclock  (clk),
      .reset       (rst),
      .ps2_clk     (ps2c),
      .ps2_data    (ps2d),
      .character   (character),
      .char_check  (char_check),
      .move_check  (move_check),
      .frame_error (frame_error)
   );

   always #20 clk = ~clk;

   // Cycle counter advancing on each active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor sampled away from the active edge.
   always @(negedge clk) begin
      n_char <= n_char + (char_check  ? 1 : 0);
      n_move <= n_move + (move_check  ? 1 : 0);
      n_err  <= n_err  + (frame_error ? 1 : 0);
      n_both <= n_both + ((char_check && move_check) ? 1 : 0);
      n_wide <= n_wide + (((char_check && prev_c) || (move_check && prev_m) ||
                           (frame_error && prev_e)) ? 1 : 0);
      if (char_check || move_check) last_pulse_cyc <= cyc;
      prev_c <= char_check;
      prev_m <= move_check;
      prev_e <= frame_error;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends the first nbits bits of a frame (11 = complete frame).
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic       par;
      logic [10:0] f;
      par = ~(^b) ^ bad_par;
      f   = {1'b1, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2d = f[i];
         wait_cycles(HALF / 2);
         ps2c = 1'b0;
         if (i == 10) fall_cyc = cyc;
         wait_cycles(HALF);
         ps2c = 1'b1;
         wait_cycles(HALF / 2);
      end
      ps2d = 1'b1;
      wait_cycles(60);
   endtask

   task automatic snap();
      c0 = n_char;
      m0 = n_move;
      e0 = n_err;
   endtask

   initial begin
      // Reset state
      wait_cycles(10);
      check("rst_char", {24'h0, character}, 32'h00);
      check("rst_cc", {31'h0, char_check}, 32'h0);
      check("rst_mc", {31'h0, move_check}, 32'h0);
      check("rst_fe", {31'h0, frame_error}, 32'h0);
      rst = 1'b0;
      wait_cycles(20);

      // 1: glyph key then its release
      snap();
      send_frame(8'h2B, 1'b0, 11);
      check("t1_cc", n_char - c0, 1);
      check("t1_char", {24'h0, character}, 32'h2B);
      check("t1_latency", ((last_pulse_cyc - fall_cyc > 0) &&
                           (last_pulse_cyc - fall_cyc <= FLEN + 4)) ? 1 : 0, 1);
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h2B, 1'b0, 11);
      check("t1_brk_cc", n_char - c0, 1);
      check("t1_brk_mc", n_move - m0, 0);
      check("t1_brk_fe", n_err - e0, 0);

      // 2: typematic move key
      snap();
      for (int k = 0; k < 3; k++) begin
         send_frame(8'h43, 1'b0, 11);
         check("t2_char", {24'h0, character}, 32'h43);
      end
      check("t2_mc", n_move - m0, 3);
      check("t2_cc", n_char - c0, 0);

      // 3: parity error
      snap();
      send_frame(8'h4B, 1'b1, 11);
      check("t3_fe", n_err - e0, 1);
      check("t3_char", {24'h0, character}, 32'h43);
      check("t3_mc", n_move - m0, 0);

      // 4: extended key ignored, then a move key
      snap();
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      check("t4_ext_mc", n_move - m0, 0);
      check("t4_ext_cc", n_char - c0, 0);
      send_frame(8'h3B, 1'b0, 11);
      check("t4_mc", n_move - m0, 1);
      check("t4_char", {24'h0, character}, 32'h3B);

      // 5: stalled frame times out, next frame decodes
      snap();
      send_frame(8'h15, 1'b0, 5);
      wait_cycles(TOUT + 100);
      check("t5_fe", n_err - e0, 1);
      check("t5_char_hold", {24'h0, character}, 32'h3B);
      send_frame(8'h15, 1'b0, 11);
      check("t5_cc", n_char - c0, 1);
      check("t5_char", {24'h0, character}, 32'h15);
      check("t5_fe_after", n_err - e0, 1);

      // 6: reset during bit 5 of 0x33
      snap();
      send_frame(8'h33, 1'b0, 6);
      @(negedge clk);
      ps2d = 1'b1;
      wait_cycles(10);
      rst = 1'b1;
      wait_cycles(3);
      check("t6_rst_char", {24'h0, character}, 32'h00);
      check("t6_rst_cc", {31'h0, char_check}, 32'h0);
      check("t6_rst_fe", {31'h0, frame_error}, 32'h0);
      rst = 1'b0;
      wait_cycles(TOUT + 100);
      check("t6_no_cc", n_char - c0, 0);
      check("t6_no_fe", n_err - e0, 0);
      check("t6_char", {24'h0, character}, 32'h00);

      // 6b: clock glitches shorter than the filter produce no strobe
      snap();
      ps2c = 1'b0;
      wait_cycles(1);
      ps2c = 1'b1;
      wait_cycles(30);
      ps2c = 1'b0;
      wait_cycles(FLEN - 1);
      ps2c = 1'b1;
      wait_cycles(TOUT + 100);
      check("t6_glitch_fe", n_err - e0, 0);
      send_frame(8'h33, 1'b0, 11);
      check("t6_cc", n_char - c0, 1);
      check("t6_char2", {24'h0, character}, 32'h33);
      check("t6_glitch_fe2", n_err - e0, 0);

      // Global pulse properties
      check("excl", n_both, 0);
      check("width", n_wide, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
